multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback,
//  drives all datapath strobes and muxes, and supplies aluop1/aluop0 to the ALU control unit.
//  Waits on a memory-ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W    16         width of retired-instruction counter
//  NORI_OP  6'b001110  opcode of nori (the ALU control unit maps aluop=11 to NOR)
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  opcode       in   6      IR[31:26]; stable from DECODE until the next FETCH
//  zero         in   1      ALU zero flag
//  neg          in   1      ALU result[31] (sign)
//  mem_ready    in   1      memory completes current read/write this cycle
//  memread      out  1      memory read enable
//  memwrite     out  1      memory write enable
//  iord         out  1      0=PC addresses memory, 1=ALUOut addresses memory
//  irwrite      out  1      load IR
//  regdst       out  1      0=rt, 1=rd write register
//  memtoreg     out  1      0=ALUOut, 1=MDR to register write data
//  regwrite     out  1      register file write enable
//  alusrca      out  1      0=PC, 1=A
//  alusrcb      out  2      00=B, 01=4, 10=signext imm, 11=signext imm<<2
//  aluop1,aluop0 out 1,1    to ALU control: 00 add, 01 sub(branch), 10 R-type funct, 11 nor
//  pcsource     out  2      00=ALU result, 01=ALUOut, 10=jump target
//  pcen         out  1      PC write enable (unconditional or branch-qualified)
//  illegal      out  1      sticky: unsupported opcode decoded
//  state        out  4      current state encoding (debug)
//  instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 JUMP=9
//    NORIEX=10 NORIWB=11 TRAP=12. Encodings 13-15 -> FETCH next cycle, all strobes 0.
//  Outputs are Moore-decoded from state; only pcen/irwrite in FETCH and pcen in BRANCH use inputs.
//  Unlisted outputs are 0 in every state.
//  FETCH: memread=1 iord=0 alusrca=0 alusrcb=01 aluop=00 pcsource=00;
//    irwrite=pcen=mem_ready; -> DECODE on mem_ready, else hold.
//  DECODE: alusrca=0 alusrcb=11 aluop=00. Opcode dispatch: 000000->EXEC; 100011/101011->MEMADR;
//    000100/000001->BRANCH; 000010->JUMP; NORI_OP->NORIEX; any other->TRAP.
//  MEMADR: alusrca=1 alusrcb=10 aluop=00; lw->MEMRD, sw->MEMWR.
//  MEMRD: memread=1 iord=1; -> MEMWB on mem_ready, else hold. MEMWB: regwrite=1 memtoreg=1 regdst=0.
//  MEMWR: memwrite=1 iord=1; -> FETCH on mem_ready, else hold (memwrite held high while waiting).
//  EXEC: alusrca=1 alusrcb=00 aluop=10 -> ALUWB. ALUWB: regwrite=1 regdst=1 memtoreg=0.
//  NORIEX: alusrca=1 alusrcb=10 aluop=11 -> NORIWB. NORIWB: regwrite=1 regdst=0 memtoreg=0.
//  BRANCH: alusrca=1 alusrcb=00 aluop=01 pcsource=01; pcen = zero (beq 000100) or neg (bltz 000001).
//  JUMP: pcsource=10 pcen=1.
//  MEMWB, ALUWB, NORIWB, BRANCH, JUMP and completed MEMWR return to FETCH.
//  TRAP: illegal set to 1, all strobes 0, state held until reset.
//  instr_count +1 on each transition into FETCH from a retiring state; 2^CNT_W-1 wraps to 0.
//  Reset (sync): state=FETCH, instr_count=0, illegal=0. While reset=1, memwrite, regwrite, irwrite
//    and pcen are forced 0 whatever the state; reset mid-instruction aborts it, no count increment.
//  Cycle counts with mem_ready=1: R/nori/lw 4/4/5, sw 4, beq/bltz 3, j 3.
// TESTING
//  add (op 000000), mem_ready=1 -> states 0,1,6,7,0; regwrite=1 regdst=1 in ALUWB; aluop=10 in EXEC;
//    count 0->1.
//  lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, memread=iord=1 throughout;
//    MEMWB regwrite=1 memtoreg=1.
//  beq zero=0 then zero=1; bltz neg=1 -> pcen 0,1,1 in BRANCH; pcsource=01 aluop=01.
//  opcode 111111 in DECODE -> TRAP, illegal=1 sticky, no strobes for 20 cycles; reset -> FETCH,
//    illegal=0.
//  reset asserted in MEMWR -> memwrite=0 that cycle, FETCH next cycle, instr_count=0.
//  CNT_W=4: run 16 nori (NORI_OP) instructions -> aluop=11 in NORIEX, instr_count wraps 15->0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each
// instruction, drives datapath strobes and counts retired instructions.
module multicycle_control #(
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  NORI_OP = 6'b001110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             neg,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             aluop1,
    output logic             aluop0,
    output logic [1:0]       pcsource,
    output logic             pcen,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_NORIEX = 4'd10,
        S_NORIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_irwrite;
    logic       w_pcen;
    logic [1:0] w_aluop;
    logic       w_retiring;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
            if (w_retiring)
                r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        memread    = 1'b0;
        w_memwrite = 1'b0;
        iord       = 1'b0;
        w_irwrite  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_regwrite = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        w_aluop    = 2'b00;
        pcsource   = 2'b00;
        w_pcen     = 1'b0;
        w_retiring = 1'b0;
        case (r_state)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcen    = mem_ready;
                if (mem_ready)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (opcode == OP_RTYPE)
                    w_next = S_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW)
                    w_next = S_MEMADR;
                else if (opcode == OP_BEQ || opcode == OP_BLTZ)
                    w_next = S_BRANCH;
                else if (opcode == OP_J)
                    w_next = S_JUMP;
                else if (opcode == NORI_OP)
                    w_next = S_NORIEX;
                else
                    w_next = S_TRAP;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                w_next     = S_FETCH;
                w_retiring = 1'b1;
            end
            S_MEMWR: begin
                w_memwrite = 1'b1;
                iord       = 1'b1;
                if (mem_ready) begin
                    w_next     = S_FETCH;
                    w_retiring = 1'b1;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                w_aluop = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
                w_next     = S_FETCH;
                w_retiring = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                w_aluop    = 2'b01;
                pcsource   = 2'b01;
                w_pcen     = (opcode == OP_BEQ)  ? zero :
                             (opcode == OP_BLTZ) ? neg  : 1'b0;
                w_next     = S_FETCH;
                w_retiring = 1'b1;
            end
            S_JUMP: begin
                pcsource   = 2'b10;
                w_pcen     = 1'b1;
                w_next     = S_FETCH;
                w_retiring = 1'b1;
            end
            S_NORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluop = 2'b11;
                w_next  = S_NORIWB;
            end
            S_NORIWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
                w_retiring = 1'b1;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write-type strobes must never fire while reset is held.
    assign memwrite    = w_memwrite & ~reset;
    assign regwrite    = w_regwrite & ~reset;
    assign irwrite     = w_irwrite  & ~reset;
    assign pcen        = w_pcen     & ~reset;
    assign aluop1      = w_aluop[1];
    assign aluop0      = w_aluop[0];
    assign illegal     = r_illegal;
    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: an instruction-level
// model queues per-cycle expectations, a monitor compares on negedge.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          zero;
    logic          neg;
    logic          mem_ready;
    logic          memread;
    logic          memwrite;
    logic          iord;
    logic          irwrite;
    logic          regdst;
    logic          memtoreg;
    logic          regwrite;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic          aluop1;
    logic          aluop0;
    logic [1:0]    pcsource;
    logic          pcen;
    logic          illegal;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    multicycle_control #(.CNT_W(CW), .NORI_OP(6'b001110)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .neg(neg), .mem_ready(mem_ready), .memread(memread),
        .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop1(aluop1),
        .aluop0(aluop0), .pcsource(pcsource), .pcen(pcen),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic          mrd, mwr, iord, irw, rdst, m2r, rw, asa;
        logic [1:0]    asb, aop, psrc;
        logic          pcen, ill;
        logic [CW-1:0] cnt;
    } rec_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
    } ph_t;

    rec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    logic m_ill    = 1'b0;

    // Expected outputs for one cycle, read off the per-state behaviour table.
    function automatic rec_t expect_rec(input logic [3:0] st,
                                        input logic [5:0] op,
                                        input logic z, input logic n,
                                        input logic mr, input logic rst);
        rec_t r;
        r = '0;
        r.st = st;
        case (st)
            4'd0:  begin r.mrd = 1; r.asb = 2'b01; r.irw = mr; r.pcen = mr; end
            4'd1:  r.asb = 2'b11;
            4'd2:  begin r.asa = 1; r.asb = 2'b10; end
            4'd3:  begin r.mrd = 1; r.iord = 1; end
            4'd4:  begin r.rw = 1; r.m2r = 1; end
            4'd5:  begin r.mwr = 1; r.iord = 1; end
            4'd6:  begin r.asa = 1; r.aop = 2'b10; end
            4'd7:  begin r.rw = 1; r.rdst = 1; end
            4'd8:  begin
                r.asa = 1; r.aop = 2'b01; r.psrc = 2'b01;
                r.pcen = (op == 6'd4) ? z : (op == 6'd1) ? n : 1'b0;
            end
            4'd9:  begin r.psrc = 2'b10; r.pcen = 1; end
            4'd10: begin r.asa = 1; r.asb = 2'b10; r.aop = 2'b11; end
            4'd11: r.rw = 1;
            default: ;
        endcase
        if (rst) begin
            r.mwr = 0; r.rw = 0; r.irw = 0; r.pcen = 0;
        end
        r.ill = m_ill;
        r.cnt = CW'(m_cnt % (1 << CW));
        return r;
    endfunction

    task automatic cyc(input logic [3:0] st, input logic [5:0] op,
                       input logic z, input logic n,
                       input logic mr, input logic rst);
        reset     = rst;
        opcode    = op;
        zero      = z;
        neg       = n;
        mem_ready = mr;
        exp_q.push_back(expect_rec(st, op, z, n, mr, rst));
        @(posedge clk);
        #1;
    endtask

    // One legal instruction; abort_at selects a phase that sees reset.
    task automatic run_instr(input logic [5:0] op, input int wf,
                             input int wm, input logic z, input logic n,
                             input int abort_at);
        ph_t ph[$];
        logic [5:0] o;
        for (int k = 0; k <= wf; k++)
            ph.push_back('{st: 4'd0, mr: (k == wf)});
        ph.push_back('{st: 4'd1, mr: 1'($urandom)});
        case (op)
            6'd0: begin
                ph.push_back('{st: 4'd6, mr: 1'($urandom)});
                ph.push_back('{st: 4'd7, mr: 1'($urandom)});
            end
            6'd14: begin
                ph.push_back('{st: 4'd10, mr: 1'($urandom)});
                ph.push_back('{st: 4'd11, mr: 1'($urandom)});
            end
            6'd35: begin
                ph.push_back('{st: 4'd2, mr: 1'($urandom)});
                for (int k = 0; k <= wm; k++)
                    ph.push_back('{st: 4'd3, mr: (k == wm)});
                ph.push_back('{st: 4'd4, mr: 1'($urandom)});
            end
            6'd43: begin
                ph.push_back('{st: 4'd2, mr: 1'($urandom)});
                for (int k = 0; k <= wm; k++)
                    ph.push_back('{st: 4'd5, mr: (k == wm)});
            end
            6'd2:    ph.push_back('{st: 4'd9, mr: 1'($urandom)});
            default: ph.push_back('{st: 4'd8, mr: 1'($urandom)});
        endcase
        for (int i = 0; i < ph.size(); i++) begin
            o = (ph[i].st == 4'd0) ? 6'($urandom) : op;
            cyc(ph[i].st, o, z, n, ph[i].mr, i == abort_at);
            if (i == abort_at) begin
                m_cnt = 0;
                m_ill = 1'b0;
                return;
            end
        end
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd1, 6'd2, 6'd14};
    endfunction

    task automatic run_trap(input logic [5:0] op, input int hold);
        cyc(4'd0, 6'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        cyc(4'd1, op, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        m_ill = 1'b1;
        for (int k = 0; k < hold; k++)
            cyc(4'd12, op, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        cyc(4'd12, op, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        m_cnt = 0;
        m_ill = 1'b0;
    endtask

    initial begin : monitor
        rec_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, memread, memwrite, iord, irwrite, regdst,
                     memtoreg, regwrite, alusrca, alusrcb,
                     aluop1, aluop0, pcsource, pcen, illegal, instr_count};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle st=%0d t=%0t got=%h want=%h",
                             e.st, $time, a, e);
                end
            end
        end
    end

    initial begin : stim
        logic [5:0] legal [7];
        logic [5:0] op;
        legal = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd1, 6'd2, 6'd14};
        reset = 1; opcode = 0; zero = 0; neg = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        cyc(4'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        run_instr(6'd0, 0, 0, 1'b0, 1'b0, -1);
        run_instr(6'd35, 1, 3, 1'b0, 1'b0, -1);
        run_instr(6'd4, 0, 0, 1'b0, 1'b1, -1);
        run_instr(6'd4, 0, 0, 1'b1, 1'b0, -1);
        run_instr(6'd1, 0, 0, 1'b0, 1'b1, -1);
        run_instr(6'd1, 0, 0, 1'b1, 1'b0, -1);
        run_instr(6'd2, 0, 0, 1'b0, 1'b0, -1);
        run_instr(6'd43, 0, 2, 1'b0, 1'b0, -1);
        run_trap(6'b111111, 20);
        run_instr(6'd43, 0, 1, 1'b0, 1'b0, 3);
        for (int k = 0; k < 20; k++)
            run_instr(6'd14, 0, 0, 1'($urandom), 1'($urandom), -1);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
                run_trap(op, $urandom_range(1, 5));
            end else begin
                op = legal[$urandom_range(0, 6)];
                run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                          1'($urandom), 1'($urandom),
                          ($urandom_range(0, 9) == 0) ?
                              $urandom_range(0, 7) : -1);
            end
        end

        @(negedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
